trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning probe and sample width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning capture buffer entries (power of two, 4..1024); AW = clog2(DEPTH).
REQ-003 The block SHALL have parameter POST, default 4, meaning samples stored after the trigger sample (0..DEPTH-1).
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  SHALL be the reset; asynchronous, active-low.
REQ-006 Port arm  input  1  SHALL be a start-capture request, sampled each cycle.
REQ-007 Port abort  input  1  SHALL be a cancel-capture request, sampled each cycle.
REQ-008 Port probe  input  WIDTH  SHALL be the signal sampled into the buffer.
REQ-009 Port trig_value  input  WIDTH  SHALL be the trigger compare value.
REQ-010 Port trig_mask  input  WIDTH  SHALL select the probe bits compared (1 = compare).
REQ-011 Port rd_en  input  1  SHALL be the readout request.
REQ-012 Port rd_addr  input  AW  SHALL be the readout index; 0 = oldest stored sample.
REQ-013 Port rd_data  output  WIDTH  SHALL be the readout sample.
REQ-014 Port rd_valid  output  1  SHALL qualify rd_data.
REQ-015 Port busy  output  1  SHALL be high in ARMED or TRIGGERED.
REQ-016 Port done  output  1  SHALL be high in DONE.
REQ-017 Port sample_count  output  AW+1  SHALL be the number of valid stored samples (0..DEPTH).
REQ-018 Port trig_offset  output  AW  SHALL be the readout index of the trigger sample.

Function
REQ-019 The block SHALL implement states IDLE, ARMED, TRIGGERED, DONE, all outputs registered.
REQ-020 IDLE or DONE with arm=1 at edge k SHALL enter ARMED, clear write pointer and sample_count, drop done; first sample written at edge k+1.
REQ-021 ARMED and TRIGGERED SHALL write probe at the write pointer every cycle, pointer incrementing modulo DEPTH; sample_count increments, saturating at DEPTH.
REQ-022 Trigger match SHALL be ((probe ^ trig_value) & trig_mask) == 0, evaluated only in ARMED on the sample being written; trig_mask = 0 matches the first sample.
REQ-023 On match the trigger sample SHALL be stored, its pointer recorded, state -> TRIGGERED; with POST = 0 state -> DONE directly.
REQ-024 TRIGGERED SHALL store exactly POST further samples, then enter DONE; no writes in IDLE or DONE.
REQ-025 trig_offset SHALL equal (trigger pointer - oldest pointer) mod DEPTH, where oldest = (write pointer - sample_count) mod DEPTH; valid while done=1.
REQ-026 arm while busy SHALL be ignored; abort in any state SHALL enter IDLE next edge, busy=done=0; abort and arm in the same cycle: abort wins.
REQ-027 rd_en=1 in DONE at edge k SHALL give rd_valid=1 and rd_data = sample at (oldest + rd_addr) mod DEPTH after edge k (1-cycle latency); rd_addr >= sample_count SHALL return 0.
REQ-028 rd_en outside DONE SHALL give rd_valid=0, rd_data=0; rd_valid SHALL be 0 in any cycle without a qualifying rd_en.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, rd_data=0, rd_valid=0, busy=0, done=0, sample_count=0, trig_offset=0, mid-capture included.
REQ-030 Buffer contents SHALL NOT require reset; they are unreadable until the next DONE.

Verification (WIDTH=8, DEPTH=16, POST=4; probe = 0x00 on first capture edge, +1 per cycle)
REQ-031 trig_value=0x14, mask=0xFF -> DONE after sample 0x18; sample_count=16, trig_offset=11, rd_addr 0 -> 0x09, rd_addr 15 -> 0x18.
REQ-032 trig_value=0x02, mask=0xFF -> sample_count=7, trig_offset=2, rd_addr 0 -> 0x00, rd_addr 6 -> 0x06, rd_addr 7 -> 0x00.
REQ-033 trig_mask=0x00 -> trigger on 0x00, sample_count=5, trig_offset=0, rd_addr 4 -> 0x04.
REQ-034 abort in TRIGGERED -> IDLE next edge, busy=0, done=0; rd_en then gives rd_valid=0.
REQ-035 rst_n low mid-ARMED, between clock edges -> all outputs 0 without waiting for clk; arm after release -> normal capture as REQ-031.
REQ-036 arm in DONE -> done=0, busy=1 next edge; arm while busy -> no restart, results match REQ-031.

Source files
------------

// File: rtl/trace_capture.sv
// Triggered logic-analyser style capture buffer: records probe samples into a
// circular buffer around a masked trigger match and offers indexed readout.
module trace_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int POST  = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] probe,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      sample_count,
  output logic [AW-1:0]    trig_offset
);

  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED, DONE} state_t;

  state_t           state_reg;
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    trig_ptr_reg;
  logic [AW-1:0]    post_cnt_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             capturing;
  logic             match;
  logic             wr_en;
  logic [AW-1:0]    wptr_next;
  logic [AW:0]      count_next;
  logic [AW-1:0]    oldest;
  logic [AW-1:0]    trig_sel;
  logic [AW-1:0]    offset_next;
  logic [AW-1:0]    rd_ptr;

  always_comb begin
    capturing   = (state_reg == ARMED) || (state_reg == TRIGGERED);
    match       = ((probe ^ trig_value) & trig_mask) == '0;
    wr_en       = capturing && !abort;
    wptr_next   = wptr_reg + 1'b1;
    count_next  = (sample_count == (AW+1)'(DEPTH)) ? sample_count : sample_count + 1'b1;
    oldest      = wptr_reg - sample_count[AW-1:0];
    rd_ptr      = oldest + rd_addr;
    // On the DONE transition the trigger pointer is either the sample being
    // written now (POST == 0) or the one recorded earlier.
    trig_sel    = (state_reg == ARMED) ? wptr_reg : trig_ptr_reg;
    offset_next = trig_sel - (wptr_next - count_next[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr_reg] <= probe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wptr_reg     <= '0;
      trig_ptr_reg <= '0;
      post_cnt_reg <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
      trig_offset  <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      if (rd_en && state_reg == DONE) begin
        rd_valid <= 1'b1;
        if ({1'b0, rd_addr} < sample_count)
          rd_data <= mem[rd_ptr];
      end

      if (abort) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            if (arm) begin
              state_reg    <= ARMED;
              wptr_reg     <= '0;
              sample_count <= '0;
              trig_offset  <= '0;
              busy         <= 1'b1;
              done         <= 1'b0;
            end
          end
          ARMED: begin
            wptr_reg     <= wptr_next;
            sample_count <= count_next;
            if (match) begin
              trig_ptr_reg <= wptr_reg;
              post_cnt_reg <= '0;
              if (POST == 0) begin
                state_reg   <= DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                trig_offset <= offset_next;
              end else begin
                state_reg <= TRIGGERED;
              end
            end
          end
          TRIGGERED: begin
            wptr_reg     <= wptr_next;
            sample_count <= count_next;
            if (post_cnt_reg == AW'(POST - 1)) begin
              state_reg   <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              trig_offset <= offset_next;
            end else begin
              post_cnt_reg <= post_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture (WIDTH=8, DEPTH=16, POST=4); readouts
// are checked through an expected-value queue.
module tb_trace_capture;

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic       abort;
  logic [7:0] probe;
  logic [7:0] trig_value;
  logic [7:0] trig_mask;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic [4:0] sample_count;
  logic [3:0] trig_offset;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];

  trace_capture #(.WIDTH(8), .DEPTH(16), .POST(4)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .probe(probe),
    .trig_value(trig_value), .trig_mask(trig_mask), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .sample_count(sample_count), .trig_offset(trig_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Issue one read; the expected {valid,data} is queued at issue and
  // compared when the registered result appears one cycle later.
  task automatic do_read(input logic [3:0] a, input logic v, input logic [7:0] d);
    logic [8:0] e;
    rd_en   = 1'b1;
    rd_addr = a;
    sb_q.push_back({v, d});
    @(negedge clk);
    rd_en = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("rd[%0d]", a), {rd_valid, rd_data}, e);
    end
  endtask

  // Arm, then feed probe = 0,1,2,... until done. If rearm_at >= 0, arm is
  // pulsed again at that probe value (should be ignored while busy).
  task automatic capture(input logic [7:0] tv, input logic [7:0] mask, input int rearm_at);
    int n;
    trig_value = tv;
    trig_mask  = mask;
    arm        = 1'b1;
    @(negedge clk);
    arm   = 1'b0;
    probe = 8'h00;
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
    chk("arm_count", sample_count, 0);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      probe = probe + 8'h01;
      arm   = (rearm_at >= 0 && int'(probe) == rearm_at);
      n++;
    end
    arm = 1'b0;
    chk("done_in_time", (n < 60), 1);
    chk("done_busy", busy, 0);
  endtask

  task automatic check_req031();
    chk("c31_count", sample_count, 16);
    chk("c31_offset", trig_offset, 11);
    do_read(4'd0, 1'b1, 8'h09);
    do_read(4'd15, 1'b1, 8'h18);
    do_read(4'd11, 1'b1, 8'h14);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; probe = '0;
    trig_value = '0; trig_mask = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_offset", trig_offset, 0);
    chk("rst_rdvalid", rd_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(4'd0, 1'b0, 8'h00);

    // trigger deep in the stream: buffer wraps, count saturates
    capture(8'h14, 8'hFF, -1);
    check_req031();

    // early trigger: partial buffer, out-of-range read returns 0
    capture(8'h02, 8'hFF, -1);
    chk("c32_count", sample_count, 7);
    chk("c32_offset", trig_offset, 2);
    do_read(4'd0, 1'b1, 8'h00);
    do_read(4'd6, 1'b1, 8'h06);
    do_read(4'd7, 1'b1, 8'h00);

    // zero mask triggers on the first sample
    capture(8'hAA, 8'h00, -1);
    chk("c33_count", sample_count, 5);
    chk("c33_offset", trig_offset, 0);
    do_read(4'd4, 1'b1, 8'h04);
    do_read(4'd0, 1'b1, 8'h00);

    // abort while TRIGGERED
    trig_value = 8'h02; trig_mask = 8'hFF; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; probe = 8'h00;
    repeat (3) begin
      @(negedge clk);
      probe = probe + 8'h01;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    do_read(4'd0, 1'b0, 8'h00);

    // abort and arm together: abort wins
    abort = 1'b1; arm = 1'b1;
    @(negedge clk);
    abort = 1'b0; arm = 1'b0;
    chk("abort_arm_busy", busy, 0);

    // asynchronous reset between edges in the middle of ARMED
    trig_value = 8'h14; trig_mask = 8'hFF; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; probe = 8'h00;
    repeat (5) begin
      @(negedge clk);
      probe = probe + 8'h01;
    end
    chk("pre_rst_count", sample_count, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", sample_count, 0);
    chk("arst_offset", trig_offset, 0);
    chk("arst_rdvalid", rd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(8'h14, 8'hFF, -1);
    check_req031();

    // re-arm from DONE, plus an ignored arm mid-capture
    capture(8'h14, 8'hFF, 5);
    check_req031();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
